// File: rtl/design_select_pkg.sv
// design_select_pkg
//   Shared types and defaults for the pad-multiplexer select controller.
//   SEL_W / FRAME_W : select code and serial frame widths
//   PARK_SEL_DEF    : select code with no design attached (all pads off)
//   MAGIC_DEF       : required header bits [7:5] of a serial frame
//   sel_state_e     : controller FSM states
package design_select_pkg;
  localparam int               SEL_W        = 5;
  localparam int               FRAME_W      = 8;
  localparam logic [SEL_W-1:0] PARK_SEL_DEF = 5'h11;
  localparam logic [2:0]       MAGIC_DEF    = 3'b101;

  typedef enum logic [2:0] {
    WAIT,
    SAMPLE,
    RUN,
    PARK,
    APPLY
  } sel_state_e;
endpackage

// File: rtl/sel_serial_rx.sv
// sel_serial_rx
//   3-wire serial frame receiver for runtime design re-select. Only built when
//   SEL_SERIAL_EN is defined; with the macro undefined this file is empty.
//   Ports:
//     clk_i, rst_i      system clock, async active-high reset
//     ser_cs_n_i        frame select, active low, asynchronous
//     ser_clk_i         bit clock, data taken on its rising edge, asynchronous
//     ser_dat_i         serial data, MSB first
//     frame_ok          1-cycle pulse: 8-bit frame with good header
//     frame_err         1-cycle pulse: non-empty frame rejected
//     frame_data        payload [4:0] of the last completed frame
`ifdef SEL_SERIAL_EN
module sel_serial_rx
  import design_select_pkg::*;
#(
  parameter logic [2:0] MAGIC = MAGIC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ser_cs_n_i,
  input  logic             ser_clk_i,
  input  logic             ser_dat_i,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [SEL_W-1:0] frame_data
);
  localparam logic [3:0] CNT_SAT = 4'(FRAME_W + 1);
  localparam logic [3:0] CNT_LEN = 4'(FRAME_W);

  // [0],[1] are the synchroniser, [2] is the delayed copy for edge detect
  logic [2:0]         r_cs_sync;
  logic [2:0]         r_clk_sync;
  logic [1:0]         r_dat_sync;
  logic [FRAME_W-1:0] r_shift;
  logic [3:0]         r_bit_cnt;

  logic w_cs_n, w_cs_fall, w_cs_rise, w_clk_rise, w_frame_good;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cs_sync  <= '1;
      r_clk_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_cs_sync  <= {r_cs_sync[1:0], ser_cs_n_i};
      r_clk_sync <= {r_clk_sync[1:0], ser_clk_i};
      r_dat_sync <= {r_dat_sync[0], ser_dat_i};
    end
  end

  assign w_cs_n       = r_cs_sync[1];
  assign w_cs_fall    = r_cs_sync[2] & ~r_cs_sync[1];
  assign w_cs_rise    = ~r_cs_sync[2] & r_cs_sync[1];
  assign w_clk_rise   = ~r_clk_sync[2] & r_clk_sync[1];
  assign w_frame_good = (r_bit_cnt == CNT_LEN) && (r_shift[FRAME_W-1 -: 3] == MAGIC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      frame_data <= '0;
    end else begin
      if (w_cs_fall) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_clk_rise && !w_cs_n) begin
        r_shift   <= {r_shift[FRAME_W-2:0], r_dat_sync[1]};
        // saturating so over-long frames stay distinguishable from 8-bit ones
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      frame_ok  <= w_cs_rise & w_frame_good;
      // an empty frame (cs_n pulse without clocks) is ignored silently
      frame_err <= w_cs_rise & (r_bit_cnt != 4'd0) & ~w_frame_good;
      if (w_cs_rise) frame_data <= r_shift[SEL_W-1:0];
    end
  end
endmodule
`endif

// File: rtl/design_select_ctrl.sv
// design_select_ctrl
//   Selecting end of the pad-multiplexer interface. Picks the initial design
//   from strap pins after reset and, when SEL_SERIAL_EN is defined, accepts a
//   runtime re-select over a 3-wire serial frame. Every runtime switch parks
//   the pads on PARK_SEL for PARK_CYCLES so two designs never drive back-to-back.
//   Build macro: SEL_SERIAL_EN (undefined: no receiver, FSM stays in RUN).
//   Ports:
//     clk_i, rst_i        system clock, async active-high reset
//     strap_i[4:0]        strap pins, asynchronous, synchronised here
//     ser_cs_n_i/clk_i/dat_i  serial re-select lines, asynchronous
//     design_sel[4:0]     registered select code to the pad multiplexer
//     sel_busy            high in every state except RUN
//     frame_err           1-cycle pulse on a rejected serial frame
module design_select_ctrl
  import design_select_pkg::*;
#(
  parameter int               STRAP_DELAY  = 16,
  parameter int               STRAP_STABLE = 4,
  parameter int               PARK_CYCLES  = 64,
  parameter logic [SEL_W-1:0] PARK_SEL     = PARK_SEL_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SEL_W-1:0] strap_i,
  input  logic             ser_cs_n_i,
  input  logic             ser_clk_i,
  input  logic             ser_dat_i,
  output logic [SEL_W-1:0] design_sel,
  output logic             sel_busy,
  output logic             frame_err
);
  localparam int CNT_MAX = (STRAP_DELAY > PARK_CYCLES) ? STRAP_DELAY : PARK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(STRAP_STABLE + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STRAP_DELAY - 1);
  localparam logic [CNT_W-1:0] PARK_LAST  = CNT_W'(PARK_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_DONE   = STB_W'(STRAP_STABLE);

  sel_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [STB_W-1:0] r_stable;
  logic [SEL_W-1:0] r_pend_sel;
  logic [SEL_W-1:0] r_strap_s1, r_strap_s2, r_strap_prev;

  logic [STB_W-1:0] w_stable_nxt;
  logic             w_acc;
  logic [SEL_W-1:0] w_fdata;

  // Strap synchroniser plus the previous synced sample for the stability run
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_strap_s1   <= '0;
      r_strap_s2   <= '0;
      r_strap_prev <= '0;
    end else begin
      r_strap_s1   <= strap_i;
      r_strap_s2   <= r_strap_s1;
      r_strap_prev <= r_strap_s2;
    end
  end

  assign w_stable_nxt = (r_strap_s2 == r_strap_prev) ? r_stable + STB_W'(1) : STB_W'(1);

`ifdef SEL_SERIAL_EN
  logic             w_rx_ok, w_rx_err;
  logic [SEL_W-1:0] w_rx_data;

  sel_serial_rx u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ser_cs_n_i (ser_cs_n_i),
    .ser_clk_i  (ser_clk_i),
    .ser_dat_i  (ser_dat_i),
    .frame_ok   (w_rx_ok),
    .frame_err  (w_rx_err),
    .frame_data (w_rx_data)
  );

  assign w_acc   = w_rx_ok;
  assign w_fdata = w_rx_data;

  // Frames finishing before the straps are accepted are dropped without error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frame_err <= 1'b0;
    else       frame_err <= w_rx_err & (r_state != WAIT) & (r_state != SAMPLE);
  end
`else
  logic w_unused_ser;
  assign w_unused_ser = ^{ser_cs_n_i, ser_clk_i, ser_dat_i};
  assign w_acc        = 1'b0;
  assign w_fdata      = '0;
  assign frame_err    = 1'b0;
`endif

  // design_sel holds cur_sel in RUN and PARK_SEL while parked. The new code is
  // loaded as PARK ends, so APPLY already drives it (still busy) and the pads
  // see PARK_SEL for exactly PARK_CYCLES cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= WAIT;
      r_cnt      <= '0;
      r_stable   <= '0;
      r_pend_sel <= '0;
      design_sel <= PARK_SEL;
      sel_busy   <= 1'b1;
    end else begin
      case (r_state)
        WAIT: begin
          if (r_cnt == DELAY_LAST) begin
            r_cnt   <= '0;
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          r_stable <= w_stable_nxt;
          if (w_stable_nxt == STB_DONE) begin
            design_sel <= r_strap_s2;
            sel_busy   <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN, APPLY: begin
          if (w_acc) begin
            r_pend_sel <= w_fdata;
            r_cnt      <= '0;
            design_sel <= PARK_SEL;
            sel_busy   <= 1'b1;
            r_state    <= PARK;
          end else begin
            sel_busy <= 1'b0;
            r_state  <= RUN;
          end
        end
        PARK: begin
          if (w_acc) begin
            // a newer frame wins and the park window starts over
            r_pend_sel <= w_fdata;
            r_cnt      <= '0;
          end else if (r_cnt == PARK_LAST) begin
            design_sel <= r_pend_sel;
            r_state    <= APPLY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= WAIT;
          r_cnt      <= '0;
          design_sel <= PARK_SEL;
          sel_busy   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_design_select_ctrl.sv
module tb_design_select_ctrl;
  localparam int         HMAX  = 16384;
  localparam int         SD    = 16;
  localparam int         SS    = 4;
  localparam int         PARK  = 64;
  localparam logic [4:0] PSEL  = 5'h11;
  localparam logic [2:0] MAGIC = 3'b101;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] strap_i = 5'h00;
  logic       ser_cs_n_i = 1'b1;
  logic       ser_clk_i = 1'b0;
  logic       ser_dat_i = 1'b0;
  logic [4:0] design_sel;
  logic       sel_busy;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [4:0] cur_m;
  logic [4:0] ds_h [HMAX];
  logic       bs_h [HMAX];
  logic       fe_h [HMAX];

  design_select_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .strap_i    (strap_i),
    .ser_cs_n_i (ser_cs_n_i),
    .ser_clk_i  (ser_clk_i),
    .ser_dat_i  (ser_dat_i),
    .design_sel (design_sel),
    .sel_busy   (sel_busy),
    .frame_err  (frame_err)
  );

  always #5 clk_i = ~clk_i;

  // trace of outputs just after each rising edge; index = edge number
  initial forever begin
    @(posedge clk_i);
    #1;
    cyc++;
    if (cyc < HMAX) begin
      ds_h[cyc] = design_sel;
      bs_h[cyc] = sel_busy;
      fe_h[cyc] = frame_err;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "timeout");
  end

  // Reset, then drive one strap value per cycle. The controller sees the pin
  // value two edges late; it accepts at the first edge after the delay window
  // where the last SS observed values agree.
  task automatic run_strap(input string name, input int mode, input logic [4:0] a, input logic [4:0] b);
    logic [4:0] inp [64];
    logic [4:0] f [64];
    int acc, rel, k;
    bit same;
    for (int i = 0; i < 64; i++) inp[i] = b;
    if (mode == 1) begin
      for (int i = 1; i <= 40; i++) inp[i] = (((i - 1) / 2) % 2 == 0) ? a : b;
    end else if (mode == 2) begin
      k = 1;
      while (k <= 35) begin
        logic [4:0] v;
        int h;
        v = 5'($urandom);
        h = $urandom_range(1, 5);
        for (int j = 0; j < h && k <= 35; j++) begin
          inp[k] = v;
          k++;
        end
      end
    end
    for (int e = 0; e < 64; e++) f[e] = (e >= 3) ? inp[e-2] : 5'h00;
    acc = -1;
    for (int e = SD + SS; e < 64; e++) begin
      if (acc < 0) begin
        same = 1'b1;
        for (int j = 1; j < SS; j++) if (f[e-j] !== f[e]) same = 1'b0;
        if (same) acc = e;
      end
    end

    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (design_sel !== PSEL) begin failures++; $display("FAIL %s reset design_sel got %h exp %h", name, design_sel, PSEL); end
    checks++;
    if (sel_busy !== 1'b1) begin failures++; $display("FAIL %s reset sel_busy got %b exp 1", name, sel_busy); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL %s reset frame_err got %b exp 0", name, frame_err); end
    repeat (2) @(negedge clk_i);
    rel = cyc;
    rst_i = 1'b0;
    strap_i = inp[1];
    for (int i = 2; i < 64; i++) begin
      @(negedge clk_i);
      strap_i = inp[i];
    end
    @(negedge clk_i);
    for (int e = 1; e < 64; e++) begin
      logic [4:0] eds;
      logic       eb;
      eds = (e >= acc) ? f[acc] : PSEL;
      eb  = (e < acc);
      checks++;
      if (ds_h[rel+e] !== eds) begin failures++; $display("FAIL %s edge %0d design_sel got %h exp %h", name, e, ds_h[rel+e], eds); end
      checks++;
      if (bs_h[rel+e] !== eb) begin failures++; $display("FAIL %s edge %0d sel_busy got %b exp %b", name, e, bs_h[rel+e], eb); end
    end
    cur_m = f[acc];
  endtask

  task automatic send_frame(input logic [9:0] bits, input int n, input int hp, output int rise);
    @(negedge clk_i);
    ser_cs_n_i = 1'b0;
    repeat (hp) @(negedge clk_i);
    for (int i = n - 1; i >= 0; i--) begin
      ser_dat_i = bits[i];
      ser_clk_i = 1'b0;
      repeat (hp) @(negedge clk_i);
      ser_clk_i = 1'b1;
      repeat (hp) @(negedge clk_i);
    end
    ser_clk_i = 1'b0;
    repeat (hp) @(negedge clk_i);
    ser_cs_n_i = 1'b1;
    rise = cyc;
    repeat (hp) @(negedge clk_i);
  endtask

  function automatic int first_busy(input int from);
    for (int i = from + 1; i <= from + 12; i++) if (bs_h[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int busy_len(input int s);
    int n = 0;
    while (s + n < HMAX && bs_h[s+n] === 1'b1 && n < 1000) n++;
    return n;
  endfunction

  // A frame that must not change design_sel; exp_err = number of frame_err pulses.
  task automatic test_frame_rejected(input string name, input logic [9:0] bits, input int n, input int exp_err);
    int r, ne, nd, nb;
    send_frame(bits, n, $urandom_range(3, 5), r);
    repeat (20) @(negedge clk_i);
    ne = 0; nd = 0; nb = 0;
    for (int i = r; i <= r + 20; i++) begin
      if (fe_h[i] === 1'b1) ne++;
      if (ds_h[i] !== cur_m) nd++;
      if (bs_h[i] !== 1'b0) nb++;
    end
    checks++;
    if (ne != exp_err) begin failures++; $display("FAIL %s frame_err pulses got %0d exp %0d", name, ne, exp_err); end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL %s design_sel changed in %0d cycles exp 0 (hold %h)", name, nd, cur_m); end
    checks++;
    if (nb != 0) begin failures++; $display("FAIL %s sel_busy high in %0d cycles exp 0", name, nb); end
  endtask

`ifdef SEL_SERIAL_EN
  task automatic test_switch(input string name, input logic [4:0] pay, input int hp);
    int r, s, bad, ne;
    logic [4:0] old;
    old = cur_m;
    send_frame({2'b00, MAGIC, pay}, 8, hp, r);
    repeat (PARK + 20) @(negedge clk_i);
    cur_m = pay;
    s = first_busy(r);
    checks++;
    if (s < 0) begin failures++; $display("FAIL %s accept: sel_busy got 0 for 12 cycles exp 1", name); return; end
    checks++;
    if (ds_h[s-1] !== old) begin failures++; $display("FAIL %s pre-park design_sel got %h exp %h", name, ds_h[s-1], old); end
    bad = 0; ne = 0;
    for (int i = 0; i < PARK; i++) if (ds_h[s+i] !== PSEL) bad++;
    for (int i = r; i <= s + PARK + 2; i++) if (fe_h[i] === 1'b1) ne++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s park window non-PARK_SEL cycles got %0d exp 0", name, bad); end
    checks++;
    if (ds_h[s+PARK] !== pay) begin failures++; $display("FAIL %s new design_sel got %h exp %h", name, ds_h[s+PARK], pay); end
    checks++;
    if (busy_len(s) != PARK + 1) begin failures++; $display("FAIL %s sel_busy length got %0d exp %0d", name, busy_len(s), PARK + 1); end
    checks++;
    if (ne != 0) begin failures++; $display("FAIL %s frame_err pulses got %0d exp 0", name, ne); end
  endtask

  task automatic test_restart;
    int r1, r2, s, d, bad;
    send_frame({2'b00, 8'hBE}, 8, 3, r1);
    send_frame({2'b00, 8'hA3}, 8, 3, r2);
    d = r2 - r1;
    repeat (PARK + 20) @(negedge clk_i);
    cur_m = 5'h03;
    s = first_busy(r1);
    checks++;
    if (s < 0) begin failures++; $display("FAIL restart accept: sel_busy got 0 exp 1"); return; end
    bad = 0;
    for (int i = 0; i < d + PARK; i++) if (ds_h[s+i] !== PSEL) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL restart park window non-PARK_SEL cycles got %0d exp 0", bad); end
    checks++;
    if (ds_h[s+d+PARK] !== 5'h03) begin failures++; $display("FAIL restart final design_sel got %h exp 03", ds_h[s+d+PARK]); end
    checks++;
    if (busy_len(s) != d + PARK + 1) begin failures++; $display("FAIL restart sel_busy length got %0d exp %0d", busy_len(s), d + PARK + 1); end
  endtask

  task automatic test_random_frames;
    for (int it = 0; it < 8; it++) begin
      logic [9:0] bits;
      int n;
      bits = 10'($urandom);
      if ($urandom_range(0, 1) == 1) bits[7:5] = MAGIC;
      n = $urandom_range(7, 9);
      if (n == 8 && bits[7:5] == MAGIC) test_switch("rand_ok", bits[4:0], $urandom_range(3, 5));
      else test_frame_rejected("rand_bad", bits, n, 1);
    end
  endtask

  task automatic test_reset_park;
    int r;
    send_frame({2'b00, MAGIC, 5'($urandom)}, 8, 4, r);
    repeat (10) @(negedge clk_i);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (design_sel !== PSEL) begin failures++; $display("FAIL reset_park design_sel got %h exp %h", design_sel, PSEL); end
    checks++;
    if (sel_busy !== 1'b1) begin failures++; $display("FAIL reset_park sel_busy got %b exp 1", sel_busy); end
    run_strap("reset_park_reread", 0, 5'h00, 5'($urandom));
  endtask
`endif

  initial begin
    run_strap("strap_const", 0, 5'h1B, 5'h1B);
    run_strap("strap_toggle", 1, 5'h1B, 5'h1A);
    for (int i = 0; i < 3; i++) run_strap("strap_rand", 2, 5'h00, 5'($urandom));
    run_strap("strap_base", 0, 5'h1B, 5'h1B);
`ifdef SEL_SERIAL_EN
    test_switch("switch_1e", 5'h1E, 4);
    test_frame_rejected("bad_header", 10'h07E, 8, 1);
    test_frame_rejected("short7", 10'h051, 7, 1);
    test_frame_rejected("empty", 10'h000, 0, 0);
    test_switch("same_sel", 5'h1E, 3);
    test_switch("park_sel", PSEL, 3);
    test_restart();
    test_random_frames();
    test_reset_park();
`else
    test_frame_rejected("noser_be", 10'h0BE, 8, 0);
    test_frame_rejected("noser_7e", 10'h07E, 8, 0);
    test_frame_rejected("noser_short", 10'h051, 7, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
